// File: rtl/data_unpacker_if.sv
// Stream bundle for the trace data unpacker:
// packed vectors in, unpacked beats out.
interface data_unpacker_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4
);
  localparam int CIW = $clog2(MAX_CHAINS);
  localparam int CW  = $clog2(N + 1);

  logic                           valid_in;
  logic                           ready_out;
  logic [CIW-1:0]                 chainId_in;
  logic [N-1:0][DATA_WIDTH-1:0]   vector_in;

  logic [N-1:0][DATA_WIDTH-1:0]   vector_out;
  logic [CW-1:0]                  count_out;
  logic                           last_out;
  logic                           valid_out;
  logic                           ready_in;

  modport master (
    output valid_in,
    output chainId_in,
    output vector_in,
    output ready_in,
    input  ready_out,
    input  vector_out,
    input  count_out,
    input  last_out,
    input  valid_out
  );

  modport slave (
    input  valid_in,
    input  chainId_in,
    input  vector_in,
    input  ready_in,
    output ready_out,
    output vector_out,
    output count_out,
    output last_out,
    output valid_out
  );
endinterface

// File: rtl/data_unpacker.sv
// Trace data unpacker: splits N-lane packed vectors
// into beats of N, M or 1 lanes per chain firmware.
module data_unpacker #(
  parameter int N          = 8,
  parameter int M          = 2,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4,
  parameter logic [7:0] PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [MAX_CHAINS*8-1:0]
    INITIAL_FIRMWARE = '0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tracing,
  input  logic [7:0] configId,
  input  logic [7:0] configData,
  data_unpacker_if.slave bus
);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);
  localparam int W  = N * DATA_WIDTH;

  localparam logic [CW-1:0] BN = CW'(N);
  localparam logic [CW-1:0] BM = CW'(M);
  localparam logic [CW-1:0] B1 = CW'(1);
  localparam logic [KW-1:0] LN = KW'(0);
  localparam logic [KW-1:0] LM = KW'(N / M - 1);
  localparam logic [KW-1:0] L1 = KW'(N - 1);

  typedef enum logic {EMPTY, BUSY} state_t;
  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

  state_t        state_q;
  vec_t          buf_q;
  logic [1:0]    mode_q;
  logic [KW-1:0] k_q;
  logic [7:0]    fw_q [MAX_CHAINS];
  logic [7:0]    byte_cnt_q;

  logic [7:0]    acc_fw;
  logic          acc;
  logic          take;
  logic          fire;

  vec_t          src_buf;
  logic [1:0]    src_mode;
  logic [KW-1:0] src_k;
  logic [CW-1:0] bsz;
  logic [KW-1:0] lst;
  logic [W-1:0]  mask;
  vec_t          nxt_vec;
  logic          nxt_last;

  assign acc_fw = fw_q[bus.chainId_in];

  assign bus.ready_out = tracing &
    ((state_q == EMPTY) |
     (bus.ready_in & bus.last_out));

  assign acc  = bus.valid_in & bus.ready_out;
  assign take = acc & (acc_fw < 8'd3);
  assign fire = bus.valid_out & bus.ready_in;

  // Next beat comes from the incoming vector on
  // accept, otherwise from the held buffer at k+1.
  always_comb begin
    src_buf  = take ? bus.vector_in : buf_q;
    src_mode = take ? acc_fw[1:0] : mode_q;
    src_k    = take ? '0 : k_q + KW'(1);
    bsz      = B1;
    lst      = L1;
    unique case (1'b1)
      (src_mode == 2'd0): begin
        bsz = BN;
        lst = LN;
      end
      (src_mode == 2'd1): begin
        bsz = BM;
        lst = LM;
      end
      default: begin
        bsz = B1;
        lst = L1;
      end
    endcase
    mask = ~({W{1'b1}} <<
      (int'(bsz) * DATA_WIDTH));
    nxt_vec = (src_buf >>
      (int'(src_k) * int'(bsz) * DATA_WIDTH))
      & mask;
    nxt_last = (src_k == lst);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= EMPTY;
      buf_q          <= '0;
      mode_q         <= '0;
      k_q            <= '0;
      bus.valid_out  <= 1'b0;
      bus.vector_out <= '0;
      bus.count_out  <= '0;
      bus.last_out   <= 1'b0;
    end else if (take) begin
      state_q        <= BUSY;
      buf_q          <= bus.vector_in;
      mode_q         <= acc_fw[1:0];
      k_q            <= '0;
      bus.valid_out  <= 1'b1;
      bus.vector_out <= nxt_vec;
      bus.count_out  <= bsz;
      bus.last_out   <= nxt_last;
    end else if (fire) begin
      if (!bus.last_out) begin
        k_q            <= src_k;
        bus.vector_out <= nxt_vec;
        bus.last_out   <= nxt_last;
      end else begin
        state_q        <= EMPTY;
        bus.valid_out  <= 1'b0;
        bus.vector_out <= '0;
        bus.count_out  <= '0;
        bus.last_out   <= 1'b0;
      end
    end
  end

  // Firmware bytes stream in while tracing is low;
  // any foreign configId restarts the byte sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt_q <= '0;
      for (int i = 0; i < MAX_CHAINS; i++)
        fw_q[i] <= INITIAL_FIRMWARE[i*8 +: 8];
    end else if (!tracing) begin
      if (configId == PERSONAL_CONFIG_ID) begin
        for (int i = 0; i < MAX_CHAINS; i++)
          if (byte_cnt_q == 8'(i))
            fw_q[i] <= configData;
        if (byte_cnt_q != 8'hff)
          byte_cnt_q <= byte_cnt_q + 8'd1;
      end else begin
        byte_cnt_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_data_unpacker.sv
// Bench for data_unpacker: directed scenarios plus
// random traffic against a beat-queue reference model.
module tb_data_unpacker;
  localparam int N  = 8;
  localparam int M  = 2;
  localparam int DW = 32;
  localparam int MC = 4;
  localparam int W  = N * DW;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tracing = 1'b1;
  logic [7:0] cfg_id = 8'd0;
  logic [7:0] cfg_data = 8'd0;

  always #5 clk = ~clk;

  data_unpacker_if #(
    .N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC)
  ) bus ();

  data_unpacker #(
    .N(N), .M(M), .DATA_WIDTH(DW), .MAX_CHAINS(MC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tracing    (tracing),
    .configId   (cfg_id),
    .configData (cfg_data),
    .bus        (bus.slave)
  );

  typedef struct {
    logic [W-1:0] v;
    int           c;
    bit           l;
  } beat_t;

  beat_t q[$];
  int    fw[MC];
  int    bcnt;
  int    total  = 0;
  int    passed = 0;
  bit    acc_seen = 1'b0;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  function automatic logic [W-1:0] seq_vec(int base);
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(base + i);
    return v;
  endfunction

  // Expected beats of one vector, straight from the mode rule.
  task automatic push_vec(input int mode,
                          input logic [W-1:0] v);
    int    b;
    beat_t bt;
    if (mode > 2) return;
    b = (mode == 0) ? N : (mode == 1) ? M : 1;
    for (int k = 0; k < N / b; k++) begin
      bt.v = '0;
      for (int i = 0; i < b; i++)
        bt.v[i*DW +: DW] = v[(k*b + i)*DW +: DW];
      bt.c = b;
      bt.l = (k == N / b - 1);
      q.push_back(bt);
    end
  endtask

  task automatic check_out();
    chk("valid_out", W'(bus.valid_out), W'(q.size() > 0));
    if (q.size() > 0) begin
      chk("vector_out", bus.vector_out, q[0].v);
      chk("count_out", W'(bus.count_out), W'(q[0].c));
      chk("last_out", W'(bus.last_out), W'(q[0].l));
    end
  endtask

  // One cycle: inputs were set at the falling edge.
  task automatic step();
    bit           er, fire, acc, tr;
    logic [W-1:0] vin;
    int           ch;
    logic [7:0]   id, dat;
    #1;
    er = tracing && (q.size() == 0 ||
         (q.size() == 1 && bus.ready_in));
    chk("ready_out", W'(bus.ready_out), W'(er));
    fire = (q.size() > 0) && bus.ready_in;
    acc  = bus.valid_in && er;
    vin  = bus.vector_in;
    ch   = int'(bus.chainId_in);
    tr   = tracing;
    id   = cfg_id;
    dat  = cfg_data;
    @(posedge clk);
    if (fire) void'(q.pop_front());
    if (acc) push_vec(fw[ch], vin);
    acc_seen = acc;
    if (!tr) begin
      if (id == 8'd0) begin
        if (bcnt < MC) fw[bcnt] = int'(dat);
        if (bcnt < 255) bcnt++;
      end else begin
        bcnt = 0;
      end
    end
    @(negedge clk);
    check_out();
  endtask

  task automatic send_vec(input int ch,
                          input logic [W-1:0] v);
    bus.valid_in   = 1'b1;
    bus.chainId_in = 2'(ch);
    bus.vector_in  = v;
    acc_seen = 1'b0;
    for (int n = 0; n < 60 && !acc_seen; n++) step();
    if (!acc_seen) begin
      total++;
      $error("FAIL accept_timeout observed=none expected=accept");
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic drain();
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    for (int n = 0; n < 40 && q.size() > 0; n++) step();
    if (q.size() > 0) begin
      total++;
      $error("FAIL drain_timeout observed=%0d expected=0",
             q.size());
    end
  endtask

  task automatic cfg_write(input int b0, input int b1,
                           input int b2, input int b3,
                           input int nb);
    int bytes[4];
    bytes = '{b0, b1, b2, b3};
    tracing = 1'b0;
    cfg_id  = 8'd0;
    for (int i = 0; i < nb; i++) begin
      cfg_data = 8'(bytes[i]);
      step();
    end
    cfg_id = 8'd3;
    step();
    tracing = 1'b1;
  endtask

  initial begin
    int nacc;
    bus.valid_in   = 1'b0;
    bus.chainId_in = '0;
    bus.vector_in  = '0;
    bus.ready_in   = 1'b1;
    for (int i = 0; i < MC; i++) fw[i] = 0;
    bcnt = 0;

    #1;
    chk("rst_valid", W'(bus.valid_out), W'(0));
    chk("rst_count", W'(bus.count_out), W'(0));
    chk("rst_last", W'(bus.last_out), W'(0));
    chk("rst_vector", bus.vector_out, W'(0));
    chk("rst_ready", W'(bus.ready_out), W'(1));
    @(negedge clk);
    reset_n = 1'b1;

    // chain0 mode0, chain1 mode2, chain2 drop, chain3 mode1
    cfg_write(0, 2, 5, 1, 4);

    send_vec(0, seq_vec(0));
    drain();
    send_vec(1, seq_vec(0));
    drain();

    // mode 1, two back-to-back vectors, ready toggling
    bus.valid_in   = 1'b1;
    bus.chainId_in = 2'd3;
    bus.vector_in  = seq_vec(0);
    nacc = 0;
    for (int c = 0; c < 40 && (nacc < 2 || q.size() > 0);
         c++) begin
      bus.ready_in = (c % 2 == 0);
      step();
      if (acc_seen) begin
        nacc++;
        bus.vector_in = seq_vec(8);
        if (nacc == 2) bus.valid_in = 1'b0;
      end
    end
    chk("b2b_accepts", W'(nacc), W'(2));
    drain();

    send_vec(2, seq_vec(0));
    step();
    step();

    cfg_write(2, 1, 0, 7, 4);
    send_vec(0, seq_vec(16));
    // rewrite chain0/chain1 while the vector drains
    bus.ready_in = 1'b0;
    tracing = 1'b0;
    cfg_id  = 8'd0;
    cfg_data = 8'd1;
    step();
    bus.ready_in = 1'b1;
    cfg_data = 8'd2;
    step();
    cfg_id = 8'd3;
    for (int n = 0; n < 12; n++) step();
    tracing = 1'b1;
    drain();
    send_vec(0, seq_vec(24));
    drain();

    // reset in the middle of a mode-2 vector
    send_vec(1, seq_vec(32));
    step();
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", W'(bus.valid_out), W'(0));
    chk("arst_count", W'(bus.count_out), W'(0));
    chk("arst_vector", bus.vector_out, W'(0));
    q.delete();
    for (int i = 0; i < MC; i++) fw[i] = 0;
    bcnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 5; n++) step();

    cfg_write(1, 2, 0, 3, 4);
    acc_seen = 1'b1;
    for (int c = 0; c < 500; c++) begin
      if (!bus.valid_in || acc_seen) begin
        logic [W-1:0] v;
        bus.valid_in = ($urandom_range(0, 2) != 0);
        bus.chainId_in = 2'($urandom_range(0, MC - 1));
        for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
        bus.vector_in = v;
      end
      bus.ready_in = ($urandom_range(0, 3) != 0);
      tracing = ((c / 50) % 4 != 3);
      cfg_id = ($urandom_range(0, 4) == 0) ? 8'd3 : 8'd0;
      cfg_data = 8'($urandom_range(0, 4));
      step();
    end
    tracing = 1'b1;
    cfg_id  = 8'd3;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
